// File: rtl/bcd_game_timer.sv
// bcd_game_timer: prescaled multi-digit BCD up/down counter with active-low 7-segment outputs
module bcd_game_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_COUNT  = 50000000,
    parameter bit WRAP       = 1'b1
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic                    count_down,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic                    tick,
    output logic                    rollover,
    output logic                    done
);
    localparam int PW = $clog2(DIV_COUNT);
    localparam logic [PW-1:0] PMAX = PW'(DIV_COUNT - 1);

    logic [PW-1:0]           pre;
    logic [4*NUM_DIGITS-1:0] step_v;
    logic [4*NUM_DIGITS-1:0] sat_v;
    logic [NUM_DIGITS:0]     chain;
    logic [3:0]              lim;
    logic                    hit;
    logic                    term;
    logic                    hold;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // lim is the digit value that carries (up) or borrows (down); it also marks the terminal value
    assign lim      = count_down ? 4'd0 : 4'd9;
    assign chain[0] = 1'b1;
    assign term     = chain[NUM_DIGITS];
    assign hit      = enable && pre == PMAX;
    assign hold     = term && !WRAP;

    genvar i;
    for (i = 0; i < NUM_DIGITS; i++) begin : g_dig
        logic [3:0] d;
        logic [3:0] lv;
        assign d                 = bcd_out[4*i +: 4];
        assign lv                = load_value[4*i +: 4];
        assign chain[i+1]        = chain[i] && d == lim;
        assign step_v[4*i +: 4]  = !chain[i] ? d : d == lim ? 4'd9 - lim : count_down ? d - 4'd1 : d + 4'd1;
        assign sat_v[4*i +: 4]   = lv > 4'd9 ? 4'd9 : lv;
        assign seg_out[7*i +: 7] = seg7(d);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bcd_out  <= '0;
            pre      <= '0;
            tick     <= 1'b0;
            rollover <= 1'b0;
            done     <= 1'b0;
        end else if (clear || load) begin
            bcd_out  <= clear ? '0 : sat_v;
            pre      <= '0;
            tick     <= 1'b0;
            rollover <= 1'b0;
            done     <= 1'b0;
        end else begin
            tick     <= hit;
            rollover <= hit && term && WRAP;
            if (enable)
                pre <= hit ? '0 : pre + 1'b1;
            if (hit && hold)
                done <= 1'b1;
            if (hit && !hold)
                bcd_out <= step_v;
        end
    end
endmodule

// File: tb/tb_bcd_game_timer.sv
// tb_bcd_game_timer: integer-valued reference model plus directed and randomized checks
module tb_bcd_game_timer;
    localparam int D = 4;
    localparam int MAXV = 9999;

    typedef struct {
        logic [15:0] lv;
        logic [15:0] exp;
    } ld_vec_t;

    logic clk = 1'b0, resetn = 1'b1, en = 1'b0, cd = 1'b0, clr = 1'b0, ld = 1'b0;
    logic [15:0] lv = '0;
    logic [15:0] bcd0, bcd1;
    logic [27:0] seg0, seg1;
    logic tk0, ro0, dn0, tk1, ro1, dn1;
    logic en2 = 1'b0, ld2 = 1'b0;
    logic [3:0] lv2 = '0, bcd2;
    logic [6:0] seg2;
    logic tk2, ro2, dn2;

    int tests = 0, fails = 0;
    int mv[2], mr[2], md[2];
    int mp = 0, mt = 0;
    logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    ld_vec_t tbl[6];

    always #5 clk = ~clk;

    bcd_game_timer #(.NUM_DIGITS(4), .DIV_COUNT(D), .WRAP(1'b1)) u0 (
        .CLOCK_50(clk), .resetn(resetn), .enable(en), .count_down(cd), .clear(clr), .load(ld),
        .load_value(lv), .bcd_out(bcd0), .seg_out(seg0), .tick(tk0), .rollover(ro0), .done(dn0));
    bcd_game_timer #(.NUM_DIGITS(4), .DIV_COUNT(D), .WRAP(1'b0)) u1 (
        .CLOCK_50(clk), .resetn(resetn), .enable(en), .count_down(cd), .clear(clr), .load(ld),
        .load_value(lv), .bcd_out(bcd1), .seg_out(seg1), .tick(tk1), .rollover(ro1), .done(dn1));
    bcd_game_timer #(.NUM_DIGITS(1), .DIV_COUNT(2), .WRAP(1'b1)) u2 (
        .CLOCK_50(clk), .resetn(resetn), .enable(en2), .count_down(1'b0), .clear(1'b0), .load(ld2),
        .load_value(lv2), .bcd_out(bcd2), .seg_out(seg2), .tick(tk2), .rollover(ro2), .done(dn2));

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] to_seg(input int v);
        logic [27:0] r;
        int x = v;
        for (int k = 0; k < 4; k++) begin
            r[7*k +: 7] = segtab[x % 10];
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_sat(input logic [15:0] x);
        int v = 0;
        for (int k = 3; k >= 0; k--)
            v = v * 10 + (x[4*k +: 4] > 9 ? 9 : int'(x[4*k +: 4]));
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mp = 0; mt = 0;
        for (int w = 0; w < 2; w++) begin mv[w] = 0; mr[w] = 0; md[w] = 0; end
    endtask

    // index 0 models the wrapping instance, index 1 the saturating one
    task automatic model();
        if (clr || ld) begin
            mp = 0; mt = 0;
            for (int w = 0; w < 2; w++) begin mv[w] = clr ? 0 : from_sat(lv); mr[w] = 0; md[w] = 0; end
        end else begin
            mt = (en && mp == D - 1) ? 1 : 0;
            if (en) mp = (mp + 1) % D;
            for (int w = 0; w < 2; w++) begin
                mr[w] = 0;
                if (mt == 1) begin
                    if (mv[w] == (cd ? 0 : MAXV)) begin
                        if (w == 0) begin mv[w] = cd ? MAXV : 0; mr[w] = 1; end
                        else md[w] = 1;
                    end else mv[w] = cd ? mv[w] - 1 : mv[w] + 1;
                end
            end
        end
    endtask

    task automatic compare();
        check("bcd_w", bcd0, to_bcd(mv[0]));
        check("seg_w", seg0, to_seg(mv[0]));
        check("tick_w", tk0, mt);
        check("roll_w", ro0, mr[0]);
        check("done_w", dn0, md[0]);
        check("bcd_s", bcd1, to_bcd(mv[1]));
        check("seg_s", seg1, to_seg(mv[1]));
        check("tick_s", tk1, mt);
        check("roll_s", ro1, mr[1]);
        check("done_s", dn1, md[1]);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model();
            #1;
            compare();
        end
    endtask

    task automatic wait_tick(output int c);
        c = 0;
        do begin step(); c++; end while (!tk0 && c < 20);
        check("tick_timeout", tk0, 1);
    endtask

    initial begin
        int c, ticks, last;
        tbl[0] = '{16'hA5F3, 16'h9593};
        tbl[1] = '{16'hFFFF, 16'h9999};
        tbl[2] = '{16'h1234, 16'h1234};
        tbl[3] = '{16'h0A0B, 16'h0909};
        tbl[4] = '{16'hB000, 16'h9000};
        tbl[5] = '{16'h0000, 16'h0000};
        model_reset();
        #2 resetn = 1'b0;
        #10;
        check("rst_bcd", bcd0, 0);
        check("rst_seg", seg0, {4{7'b1000000}});
        check("rst_flags", {tk0, ro0, dn0, tk1, ro1, dn1}, 0);
        resetn = 1'b1;

        en = 1'b1;
        ticks = 0; last = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (tk0) begin
                ticks++;
                if (last >= 0) check("tick_spacing", k - last, 4);
                last = k;
            end
        end
        check("tick_count", ticks, 10);
        check("bcd_after40", bcd0, 16'h0010);
        check("seg_digit1", seg0[13:7], 7'b1111001);

        ld = 1'b1; lv = 16'h9998; step(); ld = 1'b0;
        check("load_9998", bcd0, 16'h9998);
        wait_tick(c);
        check("up_9999", bcd0, 16'h9999);
        wait_tick(c);
        check("wrap_0000", bcd0, 16'h0000);
        check("wrap_roll", ro0, 1);
        check("sat_hold", bcd1, 16'h9999);
        check("sat_done", dn1, 1);
        step();
        check("roll_one_cycle", ro0, 0);

        ld = 1'b1; lv = 16'h0001; cd = 1'b1; step(); ld = 1'b0;
        wait_tick(c);
        check("down_0000", bcd1, 16'h0000);
        check("down_no_done", dn1, 0);
        wait_tick(c);
        check("down_hold", bcd1, 16'h0000);
        check("down_done", dn1, 1);
        check("down_wrap", bcd0, 16'h9999);
        cd = 1'b0;
        wait_tick(c);
        check("resume_up", bcd1, 16'h0001);
        check("resume_done", dn1, 1);
        clr = 1'b1; step(); clr = 1'b0;
        check("clr_done", dn1, 0);
        check("clr_bcd", bcd1, 0);

        en = 1'b0;
        foreach (tbl[k]) begin
            ld = 1'b1; lv = tbl[k].lv; step();
            check("load_table", bcd0, tbl[k].exp);
        end
        clr = 1'b1; lv = 16'h1234; step(); clr = 1'b0; ld = 1'b0;
        check("clr_over_load", bcd0, 0);

        ld = 1'b1; lv = 16'h0000; en = 1'b1; step(); ld = 1'b0;
        step(2);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("pause_tick", tk0, 0);
        end
        en = 1'b1;
        step();
        check("resume_early", tk0, 0);
        step();
        check("resume_tick", tk0, 1);
        check("resume_bcd", bcd0, 16'h0001);

        en = 1'b0; ld = 1'b1; lv = 16'h0457; step(); ld = 1'b0;
        check("pre_reset", bcd0, 16'h0457);
        #3 resetn = 1'b0;
        model_reset();
        #1;
        check("async_bcd", {bcd0, bcd1}, 0);
        check("async_seg", seg0, {4{7'b1000000}});
        check("async_flags", {tk0, ro0, dn0}, 0);
        #2 resetn = 1'b1;
        en = 1'b1;
        wait_tick(c);
        check("release_latency", c, 4);

        for (int k = 0; k < 400; k++) begin
            en  = $urandom_range(0, 9) != 0;
            cd  = $urandom_range(0, 3) == 0 ? ~cd : cd;
            clr = $urandom_range(0, 59) == 0;
            ld  = $urandom_range(0, 24) == 0;
            lv  = $urandom_range(0, 2) == 0 ? 16'h9998 : $urandom_range(0, 2) == 0 ? 16'h0001 : 16'($urandom);
            step();
        end
        clr = 1'b0; ld = 1'b0; en = 1'b0;

        ld2 = 1'b1; lv2 = 4'd8; step(); ld2 = 1'b0;
        check("n1_load", bcd2, 4'd8);
        check("n1_seg8", seg2, 7'b0000000);
        en2 = 1'b1;
        step(2);
        check("n1_nine", bcd2, 4'd9);
        check("n1_tick", tk2, 1);
        step(2);
        check("n1_wrap", bcd2, 4'd0);
        check("n1_roll", ro2, 1);
        step();
        check("n1_roll_off", ro2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
